writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Registers the memory-to-writeback bus and picks the load or ALU result.
- Drives the register-file write port, the hazard/forwarding taps and the commit trace.
- Keeps a retired-instruction counter; a stalled instruction writes and retires exactly once.

Parameters:
M_TO_W_BUS_WD, 103, width of incoming bus (shared define)
W_TO_H_BUS_WD, 7, width of hazard bus (shared define)
RETIRE_CNT_WD, 64, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
previous_valid_i  in  1  memory stage holds a valid instruction
current_valid_o  out  1  writeback stage holds a valid instruction
stall_writeback  in  1  hold stage register
flush_writeback  in  1  squash stage register
m_to_w_bus  in  103  {mem_load[102], load_result[101:70], final_result[69:38], rf_write_en[37], rf_dest[36:32], pc[31:0]}
w_to_h_bus  out  7  {rf_write_en_eff[6], rf_dest[5:1], is_load[0]}
forward_result_writeback  out  32  selected write data
rf_we  out  1  register-file write strobe
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
retire_count  out  64  instructions retired since reset
debug_wb_pc  out  32  pc of committing instruction
debug_wb_rf_we  out  4  byte enables of commit write, all-ones or zero
debug_wb_rf_wnum  out  5  commit destination
debug_wb_rf_wdata  out  32  commit data

Behaviour:
- Reset (reset==0, async): bus register, valid_wb, committed_wb and retire_count all clear to 0. All outputs are 0.
- Stage register, per rising edge, in priority order:
  - flush_writeback: bus_r<=0, valid_wb<=0.
  - else if !stall_writeback: bus_r<=m_to_w_bus, valid_wb<=previous_valid_i.
  - else hold.
- current_valid_o = valid_wb.
- wdata_sel = mem_load ? load_result : final_result. This is combinational from bus_r.
- wen_eff = valid_wb & rf_write_en & (rf_dest!=0) & !committed_wb.
- Register-file port: rf_we = wen_eff; rf_waddr = rf_dest; rf_wdata = wdata_sel.
  - A write to x0 never asserts rf_we.
- committed_wb marks the current instruction as already committed:
  - Set on the edge where valid_wb & stall_writeback & !committed_wb.
  - Cleared on any edge where the stage loads (!stall_writeback) or flushes.
  - During a multi-cycle stall, rf_we and the retire increment therefore occur only in the first stall cycle.
- retire_count increments by 1 on each edge where valid_wb & !committed_wb holds.
  - No increment if flush_writeback is asserted in that same cycle.
  - Wraps modulo 2^64 with no saturation.
- Commit trace:
  - debug_wb_pc = pc.
  - debug_wb_rf_we = {4{wen_eff}}.
  - debug_wb_rf_wnum = rf_dest.
  - debug_wb_rf_wdata = wdata_sel.
  - pc is shown even when the write enable is low.
- Hazard and forwarding taps:
  - w_to_h_bus = {valid_wb & rf_write_en & (rf_dest!=0), rf_dest, mem_load & valid_wb}. This bus ignores committed_wb, so a stalled producer still forwards.
  - forward_result_writeback = wdata_sel.
- Latency: one cycle from the memory-stage bus to the register-file write.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stall: committed_wb clears, so the held instruction is discarded and not retired.

Decomposition:
- Shared header cpu_defs.vh holds:
  - M_TO_W_BUS_WD and W_TO_H_BUS_WD.
  - The bit-field offsets of m_to_w_bus, also used by the memory stage.
  - RETIRE_CNT_WD.
- No sub-module: the stage register, commit flag and counter form one flat block.

Test Plan:
- Normal ALU write: valid, rf_write_en=1, dest=5, final_result=0x1234, mem_load=0 -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire_count 0->1.
- Load select: mem_load=1, load_result=0xFFFFFF80, final_result=0x100, dest=7 -> rf_wdata=0xFFFFFF80 and w_to_h_bus[0]=1.
- x0 write: dest=0, rf_write_en=1 -> rf_we=0, debug_wb_rf_we=0, retire_count still increments.
- Stall 3 cycles with a valid write to dest=3 -> rf_we is high exactly 1 cycle and retire_count +1 total; w_to_h_bus[6]=1 for all 4 cycles.
- Flush and stall asserted together -> next cycle valid_wb=0, rf_we=0, no retire increment.
- Async reset (reset low mid-cycle, between edges) during a stall -> outputs 0 immediately and retire_count=0 after release.

Source files
------------

// File: rtl/writeback_pkg.sv
// writeback_pkg: bus widths, memory-to-writeback field layout and write-data select
package writeback_pkg;
    localparam int M_TO_W_BUS_WD = 103;
    localparam int W_TO_H_BUS_WD = 7;
    localparam int RETIRE_CNT_WD = 64;
    typedef struct packed {
        logic        mem_load;
        logic [31:0] load_result;
        logic [31:0] final_result;
        logic        rf_write_en;
        logic [4:0]  rf_dest;
        logic [31:0] pc;
    } m_to_w_t;
    function automatic logic [31:0] wdata_sel(m_to_w_t b);
        return b.mem_load ? b.load_result : b.final_result;
    endfunction
endpackage

// File: rtl/writeback.sv
// writeback: final stage register, commit-once tracking, retire counter and commit trace
module writeback
    import writeback_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     previous_valid_i,
    output logic                     current_valid_o,
    input  logic                     stall_writeback,
    input  logic                     flush_writeback,
    input  logic [M_TO_W_BUS_WD-1:0] m_to_w_bus,
    output logic [W_TO_H_BUS_WD-1:0] w_to_h_bus,
    output logic [31:0]              forward_result_writeback,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic [RETIRE_CNT_WD-1:0] retire_count,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
);
    m_to_w_t     bus_r;
    logic        valid_wb;
    logic        committed_wb;
    logic        wen_raw;
    logic        wen_eff;
    logic [31:0] wdata;
    // committed_wb keeps a stalled instruction from writing or retiring twice
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_r        <= '0;
            valid_wb     <= 1'b0;
            committed_wb <= 1'b0;
            retire_count <= '0;
        end else begin
            if (flush_writeback) begin
                bus_r        <= '0;
                valid_wb     <= 1'b0;
                committed_wb <= 1'b0;
            end else if (!stall_writeback) begin
                bus_r        <= m_to_w_t'(m_to_w_bus);
                valid_wb     <= previous_valid_i;
                committed_wb <= 1'b0;
            end else if (valid_wb) begin
                committed_wb <= 1'b1;
            end
            if (valid_wb && !committed_wb && !flush_writeback)
                retire_count <= retire_count + 1'b1;
        end
    end
    assign wdata   = wdata_sel(bus_r);
    assign wen_raw = valid_wb & bus_r.rf_write_en & (bus_r.rf_dest != 5'd0);
    assign wen_eff = wen_raw & ~committed_wb;
    assign current_valid_o          = valid_wb;
    assign rf_we                    = wen_eff;
    assign rf_waddr                 = bus_r.rf_dest;
    assign rf_wdata                 = wdata;
    // hazard tap ignores committed_wb so a stalled producer keeps forwarding
    assign w_to_h_bus               = {wen_raw, bus_r.rf_dest, bus_r.mem_load & valid_wb};
    assign forward_result_writeback = wdata;
    assign debug_wb_pc              = bus_r.pc;
    assign debug_wb_rf_we           = {4{wen_eff}};
    assign debug_wb_rf_wnum         = bus_r.rf_dest;
    assign debug_wb_rf_wdata        = wdata;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed vector table, async-reset sequence and randomized model check
module tb_writeback;
    import writeback_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        previous_valid_i = 1'b0;
    logic        stall_writeback = 1'b0;
    logic        flush_writeback = 1'b0;
    logic [102:0] m_to_w_bus = '0;
    logic        current_valid_o;
    logic [6:0]  w_to_h_bus;
    logic [31:0] forward_result_writeback;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] retire_count;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    writeback dut (
        .clk(clk), .reset(reset),
        .previous_valid_i(previous_valid_i), .current_valid_o(current_valid_o),
        .stall_writeback(stall_writeback), .flush_writeback(flush_writeback),
        .m_to_w_bus(m_to_w_bus), .w_to_h_bus(w_to_h_bus),
        .forward_result_writeback(forward_result_writeback),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_count(retire_count), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        v, st, fl, ml;
        bit [31:0] lr, fr;
        bit        we;
        bit [4:0]  d;
        bit [31:0] pc;
        bit        e_v, e_we;
        bit [4:0]  e_addr;
        bit [31:0] e_data;
        bit [6:0]  e_wh;
        bit [31:0] e_pc;
        bit [63:0] e_cnt;
    } vec_t;

    typedef struct packed {
        bit        ml;
        bit [31:0] lr, fr;
        bit        we;
        bit [4:0]  d;
        bit [31:0] pc;
    } instr_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[11];

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic drive(bit v, bit st, bit fl, bit ml, bit [31:0] lr, bit [31:0] fr,
                         bit we, bit [4:0] d, bit [31:0] pc);
        previous_valid_i = v;
        stall_writeback  = st;
        flush_writeback  = fl;
        m_to_w_bus       = {ml, lr, fr, we, d, pc};
    endtask

    function automatic vec_t mk(bit v, bit st, bit fl, bit ml, bit [31:0] lr, bit [31:0] fr,
                                bit we, bit [4:0] d, bit [31:0] pc, bit e_v, bit e_we,
                                bit [4:0] e_addr, bit [31:0] e_data, bit [6:0] e_wh,
                                bit [31:0] e_pc, bit [63:0] e_cnt);
        return '{v, st, fl, ml, lr, fr, we, d, pc, e_v, e_we, e_addr, e_data, e_wh, e_pc, e_cnt};
    endfunction

    initial begin
        instr_t    cur;
        instr_t    nxt;
        bit        has, done, wr, v, st, fl;
        bit [31:0] sel;
        longint unsigned cnt;
        //       v st fl ml lr            fr          we d  pc     | ev we addr data         wh     pc     cnt
        tbl[0]  = mk(1,0,0,0, 32'h0,        32'h1234,   1, 5, 32'h100, 1,1,5, 32'h1234,     7'h4A, 32'h100, 0);
        tbl[1]  = mk(1,0,0,1, 32'hFFFFFF80, 32'h100,    1, 7, 32'h104, 1,1,7, 32'hFFFFFF80, 7'h4F, 32'h104, 1);
        tbl[2]  = mk(1,0,0,0, 32'h0,        32'hAA,     1, 0, 32'h108, 1,0,0, 32'hAA,       7'h00, 32'h108, 2);
        tbl[3]  = mk(0,0,0,0, 32'h0,        32'h55,     1, 9, 32'h10C, 0,0,9, 32'h55,       7'h12, 32'h10C, 3);
        tbl[4]  = mk(1,0,0,0, 32'h0,        32'h33,     1, 3, 32'h110, 1,1,3, 32'h33,       7'h46, 32'h110, 3);
        tbl[5]  = mk(1,1,0,0, 32'h0,        32'h88,     1, 8, 32'h114, 1,0,3, 32'h33,       7'h46, 32'h110, 4);
        tbl[6]  = mk(1,1,0,0, 32'h0,        32'h88,     1, 8, 32'h114, 1,0,3, 32'h33,       7'h46, 32'h110, 4);
        tbl[7]  = mk(1,1,0,0, 32'h0,        32'h88,     1, 8, 32'h114, 1,0,3, 32'h33,       7'h46, 32'h110, 4);
        tbl[8]  = mk(1,0,0,0, 32'h0,        32'h88,     1, 8, 32'h114, 1,1,8, 32'h88,       7'h50, 32'h114, 4);
        tbl[9]  = mk(1,1,1,1, 32'hDEAD,     32'hBEEF,   1, 9, 32'h118, 0,0,0, 32'h0,        7'h00, 32'h0,   4);
        tbl[10] = mk(0,0,0,0, 32'h0,        32'h0,      0, 0, 32'h0,   0,0,0, 32'h0,        7'h00, 32'h0,   4);

        drive(0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", current_valid_o, 0);
        chk("reset_we", rf_we, 0);
        chk("reset_wh", w_to_h_bus, 0);
        chk("reset_cnt", retire_count, 0);
        chk("reset_pc", debug_wb_pc, 0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].ml, tbl[i].lr, tbl[i].fr,
                  tbl[i].we, tbl[i].d, tbl[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), current_valid_o, tbl[i].e_v);
            chk($sformatf("row%0d_we", i), rf_we, tbl[i].e_we);
            chk($sformatf("row%0d_dbg_we", i), debug_wb_rf_we, {4{tbl[i].e_we}});
            chk($sformatf("row%0d_addr", i), rf_waddr, tbl[i].e_addr);
            chk($sformatf("row%0d_data", i), rf_wdata, tbl[i].e_data);
            chk($sformatf("row%0d_fwd", i), forward_result_writeback, tbl[i].e_data);
            chk($sformatf("row%0d_wh", i), w_to_h_bus, tbl[i].e_wh);
            chk($sformatf("row%0d_pc", i), debug_wb_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_cnt", i), retire_count, tbl[i].e_cnt);
        end

        // async reset in the middle of a stall discards the held instruction
        @(negedge clk);
        drive(1,0,0,0,0,32'h77,1,3,32'h200);
        @(posedge clk);
        #1;
        chk("ar_load_we", rf_we, 1);
        @(negedge clk) stall_writeback = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_stall_we", rf_we, 0);
        chk("ar_stall_wh", w_to_h_bus[6], 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", current_valid_o, 0);
        chk("ar_wh", w_to_h_bus, 0);
        chk("ar_pc", debug_wb_pc, 0);
        chk("ar_cnt", retire_count, 0);
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0,0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_rel_cnt", retire_count, 0);
        chk("ar_rel_valid", current_valid_o, 0);

        cur  = '0;
        has  = 1'b0;
        done = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            v  = $urandom_range(0, 3) != 0;
            st = $urandom_range(0, 9) < 4;
            fl = $urandom_range(0, 9) == 0;
            nxt.ml = $urandom_range(0, 1);
            nxt.lr = $urandom;
            nxt.fr = $urandom;
            nxt.we = $urandom_range(0, 3) != 0;
            nxt.d  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            nxt.pc = $urandom;
            drive(v, st, fl, nxt.ml, nxt.lr, nxt.fr, nxt.we, nxt.d, nxt.pc);
            if (has && !done && !fl) cnt++;
            if (fl) begin
                cur = '0; has = 1'b0; done = 1'b0;
            end else if (!st) begin
                cur = nxt; has = v; done = 1'b0;
            end else if (has) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            sel = cur.ml ? cur.lr : cur.fr;
            wr  = has && cur.we && cur.d != 0;
            chk($sformatf("rnd%0d_valid", i), current_valid_o, has);
            chk($sformatf("rnd%0d_we", i), rf_we, wr && !done);
            chk($sformatf("rnd%0d_dbg_we", i), debug_wb_rf_we, {4{wr && !done}});
            chk($sformatf("rnd%0d_addr", i), rf_waddr, cur.d);
            chk($sformatf("rnd%0d_wnum", i), debug_wb_rf_wnum, cur.d);
            chk($sformatf("rnd%0d_data", i), rf_wdata, sel);
            chk($sformatf("rnd%0d_dbg_data", i), debug_wb_rf_wdata, sel);
            chk($sformatf("rnd%0d_fwd", i), forward_result_writeback, sel);
            chk($sformatf("rnd%0d_wh", i), w_to_h_bus, {wr, cur.d, cur.ml && has});
            chk($sformatf("rnd%0d_pc", i), debug_wb_pc, cur.pc);
            chk($sformatf("rnd%0d_cnt", i), retire_count, cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
